// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the I/D-cache memory-bus arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_sel_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request ports plus the shared line-wide memory bus.
// master = arbiter side, slave = caches/memory side.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_wdata;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selector; MEM_ARB_ROUND_ROBIN_EN picks round-robin on ties,
// otherwise the D-cache always wins a tie. Zero latency, no state.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic      req_i,
    input  logic      req_d,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  port_sel_t last_grant,
`endif
    output port_sel_t sel
);

    always_comb begin
        sel = PORT_I;
        if (req_i && req_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            sel = (last_grant == PORT_I) ? PORT_D : PORT_I;
`else
            sel = PORT_D;
`endif
        end else if (req_d) begin
            sel = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port I/D-cache arbiter onto one registered memory bus; grant to mem_* is 1 cycle,
// port ready follows mem_ready combinationally. Tie policy via MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
)(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;

    logic              w_req_i;
    logic              w_req_d;
    logic              w_grant;
    logic              w_done;
    logic              w_i_ready;
    logic              w_d_ready;
    port_sel_t         w_sel;

    assign w_req_i = bus.i_read | bus.i_write;
    assign w_req_d = bus.d_read | bus.d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_sel_t r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= PORT_I;
        end else if (w_grant) begin
            r_last_grant <= w_sel;
        end
    end

    mem_arb_pick u_pick (
        .req_i      (w_req_i),
        .req_d      (w_req_d),
        .last_grant (r_last_grant),
        .sel        (w_sel)
    );
`else
    mem_arb_pick u_pick (
        .req_i (w_req_i),
        .req_d (w_req_d),
        .sel   (w_sel)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Requests are only looked at in IDLE; a dropped strobe during BUSY is ignored.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_done       = 1'b0;
        w_i_ready    = 1'b0;
        w_d_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_i || w_req_d) begin
                    w_grant      = 1'b1;
                    w_next_state = (w_sel == PORT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I: begin
                if (bus.mem_ready) begin
                    w_i_ready    = 1'b1;
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.mem_ready) begin
                    w_d_ready    = 1'b1;
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Write wins over read when a port raises both strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant) begin
            if (w_sel == PORT_D) begin
                r_mem_write <= bus.d_write;
                r_mem_read  <= bus.d_read & ~bus.d_write;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
            end else begin
                r_mem_write <= bus.i_write;
                r_mem_read  <= bus.i_read & ~bus.i_write;
                r_mem_addr  <= bus.i_addr;
                r_mem_wdata <= bus.i_wdata;
            end
        end else if (w_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_ready   = w_i_ready;
    assign bus.d_ready   = w_d_ready;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter; tie-grant expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W_DEF), .LINE_W(LINE_W_DEF)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W_DEF), .LINE_W(LINE_W_DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic         port_d;
        logic [127:0] rdata;
    } rsp_t;

    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] I_WD = {4{32'h1111_2222}};
    localparam logic [127:0] D_WD = {4{32'hDEAD_BEEF}};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic [3:0] TIE_D = 4'b0101;   // bit k set: D wins the k-th tie
`else
    localparam logic [3:0] TIE_D = 4'b1111;
`endif

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected command at each new bus strobe and an expected
    // response at each port ready; any unexpected event is an error.
    initial begin : monitor
        logic stb_now;
        logic prev_stb;
        cmd_t cur;
        cmd_t held;
        rsp_t rsp;
        prev_stb = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_stb = 1'b0;
            end else begin
                cur     = {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata};
                stb_now = bus.mem_read | bus.mem_write;
                if (stb_now && !prev_stb) begin
                    if (exp_cmd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cmd_unexpected: got %h expected none", cur);
                    end else begin
                        held = exp_cmd_q.pop_front();
                        chk("cmd", 160'(cur), 160'(held));
                    end
                end else if (stb_now) begin
                    chk("cmd_hold", 160'(cur), 160'(held));
                end
                prev_stb = stb_now;

                if (bus.i_ready && bus.d_ready) begin
                    checks++; errors++;
                    $display("FAIL both_ready: got 1 and 1 expected at most one");
                end else if (bus.i_ready || bus.d_ready) begin
                    if (exp_rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ready_unexpected: got i=%0b d=%0b expected none",
                                 bus.i_ready, bus.d_ready);
                    end else begin
                        rsp = exp_rsp_q.pop_front();
                        chk("rsp", 160'({bus.d_ready, bus.d_ready ? bus.d_rdata : bus.i_rdata}),
                            160'(rsp));
                    end
                end
            end
        end
    end

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.mem_read || bus.mem_write) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL grant_timeout: got no strobe expected strobe within 20 cycles");
        end
    endtask

    // Memory model: after the grant, wait lat cycles and pulse mem_ready with rdata.
    task automatic serve(input int lat, input logic port_d, input logic [127:0] rdata);
        bit ok;
        wait_stb(ok);
        if (ok) begin
            repeat (lat) @(negedge clk);
            exp_rsp_q.push_back({port_d, rdata});
            bus.mem_rdata = rdata;
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst           = 1'b0;
        bus.i_read    = 1'b0; bus.i_write = 1'b0; bus.i_addr = '0; bus.i_wdata = I_WD;
        bus.d_read    = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = D_WD;
        bus.mem_rdata = '0;   bus.mem_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_read",  160'(bus.mem_read),  160'(0));
        chk("rst_mem_write", 160'(bus.mem_write), 160'(0));
        chk("rst_mem_addr",  160'(bus.mem_addr),  160'(0));
        chk("rst_mem_wdata", 160'(bus.mem_wdata), 160'(0));
        chk("rst_readies",   160'({bus.i_ready, bus.d_ready}), 160'(0));
        rst = 1'b0;

        // I-read, memory answers three cycles after the request.
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 28'h0000010;
        exp_cmd_q.push_back({1'b1, 1'b0, 28'h0000010, I_WD});
        @(negedge clk);
        chk("t1_mem_read",  160'(bus.mem_read), 160'(1));
        chk("t1_mem_addr",  160'(bus.mem_addr), 160'(28'h10));
        serve(1, 1'b0, {16{8'hA5}});
        bus.i_read = 1'b0;
        chk("t1_read_clear", 160'(bus.mem_read), 160'(0));
        chk("t1_addr_kept",  160'(bus.mem_addr), 160'(28'h10));

        // D-write with read also high: write wins.
        @(negedge clk);
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 28'h0000020;
        exp_cmd_q.push_back({1'b0, 1'b1, 28'h0000020, D_WD});
        serve(1, 1'b1, {4{32'h0BAD_F00D}});
        bus.d_read = 1'b0; bus.d_write = 1'b0;

        // Simultaneous requests held for four back-to-back grants, from reset.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.i_read = 1'b1; bus.i_addr = 28'h0000100;
        bus.d_read = 1'b1; bus.d_addr = 28'h0000200;
        for (int k = 0; k < 4; k++) begin
            if (TIE_D[k]) exp_cmd_q.push_back({1'b1, 1'b0, 28'h0000200, D_WD});
            else          exp_cmd_q.push_back({1'b1, 1'b0, 28'h0000100, I_WD});
        end
        for (int k = 0; k < 4; k++) begin
            serve(1, TIE_D[k], {4{32'hC0DE_0000 + 32'(k)}});
        end
        bus.i_read = 1'b0; bus.d_read = 1'b0;

        // D drops its read one cycle into the transaction.
        @(negedge clk);
        bus.d_read = 1'b1; bus.d_addr = 28'h0000030;
        exp_cmd_q.push_back({1'b1, 1'b0, 28'h0000030, D_WD});
        @(negedge clk);
        @(negedge clk);
        bus.d_read = 1'b0;
        chk("t4_held_read", 160'(bus.mem_read), 160'(1));
        serve(2, 1'b1, {8{16'h5A5A}});
        chk("t4_read_clear", 160'(bus.mem_read), 160'(0));
        @(negedge clk);
        chk("t4_idle", 160'({bus.mem_read, bus.mem_write}), 160'(0));

        // Spurious mem_ready while idle.
        bus.mem_ready = 1'b1; bus.mem_rdata = {16{8'hFF}};
        #1;
        chk("t5_no_ready", 160'({bus.i_ready, bus.d_ready}), 160'(0));
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("t5_still_idle", 160'({bus.mem_read, bus.mem_write}), 160'(0));

        // Reset in the second cycle of an I-read, then a fresh I-read.
        bus.i_read = 1'b1; bus.i_addr = 28'h0000040;
        exp_cmd_q.push_back({1'b1, 1'b0, 28'h0000040, I_WD});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_abort_read", 160'(bus.mem_read), 160'(0));
        chk("t6_no_i_ready", 160'(bus.i_ready),  160'(0));
        @(negedge clk);
        rst = 1'b0; bus.i_read = 1'b0;
        chk("t6_addr_reset", 160'(bus.mem_addr), 160'(0));
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 28'h0000044;
        exp_cmd_q.push_back({1'b1, 1'b0, 28'h0000044, I_WD});
        serve(1, 1'b0, {4{32'h7777_1234}});
        bus.i_read = 1'b0;

        repeat (3) @(negedge clk);
        chk("cmd_q_drained", 160'(exp_cmd_q.size()), 160'(0));
        chk("rsp_q_drained", 160'(exp_rsp_q.size()), 160'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter between the instruction cache and the data cache and the single shared line-wide memory bus. Each cache's memory-side port (read/write strobes, 28-bit line address, 128-bit line data, ready) connects to one arbiter port. The arbiter grants one port at a time, registers the granted command onto the memory bus, and routes `mem_ready` back to the granted port only.

## Interface
- `ADDR_W`, 28, line address width (word address minus 2-bit block offset)
- `LINE_W`, 128, cache line width in bits
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `i_read`, `i_write`  in  1 each  I-cache request strobes, level-held until `i_ready`
- `i_addr`  in  ADDR_W  I-cache line address
- `i_wdata`  in  LINE_W  I-cache write line
- `i_rdata`  out  LINE_W  read line to I-cache
- `i_ready`  out  1  I-cache transaction complete
- `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`: same meanings, D-cache port
- `mem_read`, `mem_write`  out  1 each  memory strobes, registered
- `mem_addr`  out  ADDR_W  registered line address
- `mem_wdata`  out  LINE_W  registered write line
- `mem_rdata`  in  LINE_W  memory read line
- `mem_ready`  in  1  memory completion, one-cycle pulse

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- In IDLE, a port is requesting if its read or its write strobe is high.
- IDLE, no request: stay in IDLE.
- IDLE, one port requesting: go to BUSY of that port.
- IDLE, both ports requesting: resolve by the grant policy (see Configuration).
- On the grant edge, latch the port's command into the `mem_*` registers:
  - `mem_write` = port write.
  - `mem_read` = port read AND NOT port write. Write wins if both strobes are high.
  - `mem_addr` and `mem_wdata` = the port's address and write line.
- BUSY_x: hold `mem_*` constant. Deasserting the port request mid-transaction is ignored; the arbiter still waits for `mem_ready`.
- BUSY_x with `mem_ready`:
  - `x_ready` = 1 combinationally in that cycle.
  - Next state IDLE.
  - `mem_read` and `mem_write` clear on that edge. `mem_addr` and `mem_wdata` keep their values.
- `i_rdata` and `d_rdata` are wired directly to `mem_rdata` at all times. Data is valid only when the port's ready is high.
- `mem_ready` in IDLE is ignored; no port ready is raised.
- A port's ready is never raised while the other port holds the grant.

## Timing
- Reset values:
  - State IDLE.
  - `mem_read` = 0, `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `i_ready` = 0, `d_ready` = 0.
  - Last-grant register = I.
- Request sampled in IDLE at edge t: `mem_*` valid from cycle t+1.
- `mem_ready` in cycle t+k: port ready in cycle t+k; `mem_read`/`mem_write` low from t+k+1.
- Minimum port-to-ready latency is 2 cycles. At least one idle bus cycle separates back-to-back transactions.
- A write-back immediately followed by a refill from the same cache is two independent transactions. Under the round-robin policy the other port may be granted between them.
- Reset asserted mid-transaction: return to IDLE immediately and drop the strobes. No ready is issued for the aborted transaction.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, grant the port not granted last. The last-grant register updates on every grant; its reset value I means D wins the first tie.
- Not defined: fixed priority, D-cache always wins ties. The last-grant register is not implemented.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum (IDLE, BUSY_I, BUSY_D).
  - Port-select encoding (PORT_I, PORT_D).
  - Default widths `ADDR_W_DEF` = 28 and `LINE_W_DEF` = 128.
- One sub-module, `mem_arb_pick`: combinational grant selector.
  - Inputs: `req_i`, `req_d`, `last_grant`.
  - Output: `sel`.
  - Contains the macro-dependent policy. The top-level FSM and command registers stay policy-free.

## Test plan
- Reset, then I-read at `i_addr` = 28'h0000010, memory `mem_ready` after 3 cycles with `mem_rdata` = 128'hA5…A5 → `mem_read` = 1 and `mem_addr` = 0x10 one cycle after request; `i_ready` = 1 with `i_rdata` = A5…A5; `d_ready` stays 0.
- D-write and D-read both asserted, `d_addr` = 0x20 → `mem_write` = 1, `mem_read` = 0, `mem_wdata` = `d_wdata`.
- I and D request in the same cycle, repeated 4 times with immediate re-request:
  - With the macro: grants D, I, D, I.
  - Without the macro: grants D, D, D, D while D keeps requesting.
- D-cache drops `d_read` one cycle into BUSY_D → `mem_read` and `mem_addr` stay held until `mem_ready`; `d_ready` pulses once; state returns to IDLE.
- Spurious `mem_ready` in IDLE → no `i_ready`/`d_ready`, no state change.
- `rst` asserted in cycle 2 of a BUSY_I transaction → `mem_read` = 0 from the next edge, `i_ready` never raised, then a fresh I-read completes normally.
